// File: rtl/mod_pkg.sv
// Shared definitions for the modulo 2^N+-1 reduction datapath: selector
// encodings, buffer states, default width and modulus constants.
package mod_pkg;

    localparam int unsigned MOD_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        MOD_NONE = 2'b00,
        MOD_M1   = 2'b01,
        MOD_P1   = 2'b10
    } mod_sel_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Returns 2^n - 1 (plus = 0) or 2^n + 1 (plus = 1).
    function automatic int unsigned mod_const(input int unsigned n, input logic plus);
        int unsigned p;
        p = 32'd1 << n;
        return plus ? p + 32'd1 : p - 32'd1;
    endfunction

endpackage

// File: rtl/mod_residue_unit.sv
// Combinational reducer: signed 2N-bit value -> non-negative residue
// modulo 2^N-1 or 2^N+1, or pass-through for other selectors.
module mod_residue_unit
    import mod_pkg::*;
#(
    parameter int unsigned N = MOD_N_DEFAULT
) (
    input  logic [2*N-1:0] value,
    input  logic [1:0]     mod_sel,
    output logic [2*N-1:0] result
);

    localparam int unsigned W = N + 3;
    localparam logic [W-1:0] M_M1 = W'(mod_const(N, 1'b0));
    localparam logic [W-1:0] M_P1 = W'(mod_const(N, 1'b1));

    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] sgn;
    logic [W-1:0] t_m1;
    logic [W-1:0] t_p1;
    logic [W-1:0] r_m1;
    logic [W-1:0] r_p1;

    // Reduce any t in [0, 3m) into [0, m).
    function automatic logic [W-1:0] fold3(input logic [W-1:0] t, input logic [W-1:0] m);
        if (t >= (m << 1)) begin
            return t - (m << 1);
        end else if (t >= m) begin
            return t - m;
        end else begin
            return t;
        end
    endfunction

    assign hi  = {3'b000, value[2*N-1:N]};
    assign lo  = {3'b000, value[N-1:0]};
    assign sgn = {{(W-1){1'b0}}, value[2*N-1]};

    // The raw bit pattern U equals value + sign*2^2N, and 2^2N == 1 for both
    // moduli, so residue(value) = residue(U - sign). With 2^N == +1 / -1 this
    // becomes hi + lo - sign and lo - hi - sign; bias terms keep t in [0, 3m).
    assign t_m1 = hi + lo + (value[2*N-1] ? (M_M1 - W'(1)) : '0);
    assign t_p1 = lo + (M_P1 << 1) - hi - sgn;

    assign r_m1 = fold3(t_m1, M_M1);
    assign r_p1 = fold3(t_p1, M_P1);

    always_comb begin
        result = value;
        case (mod_sel)
            MOD_M1:  result = (2*N)'(r_m1);
            MOD_P1:  result = (2*N)'(r_p1);
            default: result = value;
        endcase
    end

endmodule

// File: rtl/mod_reduce_arbiter.sv
// Two-requester round-robin front end for the shared modulo reducer with a
// one-entry registered output buffer. MOD_REDUCE_ARB_STATS_EN adds grant counters.
module mod_reduce_arbiter
    import mod_pkg::*;
#(
    parameter int unsigned N = MOD_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [2*N-1:0] req0_value,
    input  logic [1:0]     req0_mod_sel,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [2*N-1:0] req1_value,
    input  logic [1:0]     req1_mod_sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_result,
    output logic           out_src
`ifdef MOD_REDUCE_ARB_STATS_EN
    ,
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1
`endif
);

    buf_state_e     state;
    logic           last_grant;
    logic           can_accept;
    logic           grant0;
    logic           grant1;
    logic           xfer0;
    logic           xfer1;
    logic           in_xfer;
    logic           out_xfer;
    logic [2*N-1:0] sel_value;
    logic [1:0]     sel_mod;
    logic [2*N-1:0] reduced;

    assign out_valid  = (state == BUF_FULL);
    assign can_accept = ~out_valid | out_ready;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = grant0 & can_accept & ~rst;
    assign req1_ready = grant1 & can_accept & ~rst;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign in_xfer    = xfer0 | xfer1;
    assign out_xfer   = out_valid & out_ready;

    assign sel_value = grant1 ? req1_value   : req0_value;
    assign sel_mod   = grant1 ? req1_mod_sel : req0_mod_sel;

    mod_residue_unit #(
        .N(N)
    ) u_residue (
        .value   (sel_value),
        .mod_sel (sel_mod),
        .result  (reduced)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BUF_EMPTY;
            out_result <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (in_xfer) begin
                state      <= BUF_FULL;
                out_result <= reduced;
                out_src    <= xfer1;
                last_grant <= xfer1;
            end else if (out_xfer) begin
                state <= BUF_EMPTY;
            end
        end
    end

`ifdef MOD_REDUCE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (xfer0 && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (xfer1 && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mod_reduce_arbiter.sv
// Self-checking bench for mod_reduce_arbiter (N=8): vector table, scoreboard
// model of arbitration/buffer/residues, and multi-cycle corner sequences.
module tb_mod_reduce_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_value, req1_value;
    logic [1:0]  req0_mod_sel, req1_mod_sel;
    logic        out_valid, out_ready, out_src;
    logic [15:0] out_result;
`ifdef MOD_REDUCE_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    mod_reduce_arbiter #(.N(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_value   (req0_value),
        .req0_mod_sel (req0_mod_sel),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_value   (req1_value),
        .req1_mod_sel (req1_mod_sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_src      (out_src)
`ifdef MOD_REDUCE_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
`endif
    );

    typedef struct {
        logic [15:0] res;
        logic        src;
    } exp_t;

    typedef struct {
        logic        v0;
        logic [15:0] val0;
        logic [1:0]  sel0;
        logic        v1;
        logic [15:0] val1;
        logic [1:0]  sel1;
        logic [15:0] exp_res;
        logic        exp_src;
    } vec_t;

    exp_t        sb_q[$];
    logic        m_last;
    int unsigned m_cnt0, m_cnt1;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_red(input logic [15:0] v, input logic [1:0] sel);
        longint sv, m, r;
        sv = longint'($signed(v));
        if (sel == 2'b01) m = 255;
        else if (sel == 2'b10) m = 257;
        else return v;
        r = sv % m;
        if (r < 0) r = r + m;
        return 16'(r);
    endfunction

    // One clock: check readies/outputs against the model, update it, step.
    task automatic cycle();
        exp_t e;
        logic full, can, g0, g1;
        #1;
        if (rst) begin
            chk("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
            chk("ready1_in_reset", {31'd0, req1_ready}, 32'd0);
            sb_q.delete();
            m_last = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
`ifdef MOD_REDUCE_ARB_STATS_EN
            chk("grant_cnt0", {16'd0, grant_cnt0}, m_cnt0);
            chk("grant_cnt1", {16'd0, grant_cnt1}, m_cnt1);
`endif
            full = (sb_q.size() > 0);
            chk("out_valid", {31'd0, out_valid}, {31'd0, full});
            can = !full || out_ready;
            g0  = req0_valid && (!req1_valid || m_last);
            g1  = req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0 && can});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1 && can});
            if (full) begin
                chk("out_result", {16'd0, out_result}, {16'd0, sb_q[0].res});
                chk("out_src", {31'd0, out_src}, {31'd0, sb_q[0].src});
                if (out_ready) e = sb_q.pop_front();
            end
            if (can && (g0 || g1)) begin
                e.res = g1 ? model_red(req1_value, req1_mod_sel) : model_red(req0_value, req0_mod_sel);
                e.src = g1;
                sb_q.push_back(e);
                m_last = g1;
                if (g1) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
                else    m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [15:0] a0, input logic [1:0] s0,
                         input logic v1, input logic [15:0] a1, input logic [1:0] s1,
                         input logic ordy);
        req0_valid = v0; req0_value = a0; req0_mod_sel = s0;
        req1_valid = v1; req1_value = a1; req1_mod_sel = s1;
        out_ready  = ordy;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 16'hFFFB, 2'b01, 1'b0, 16'h0000, 2'b00, 16'd250,   1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'hFFFF, 2'b10, 16'd256,   1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'd514,  2'b10, 16'd0,     1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'd300,  2'b00, 16'd300,   1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'd510,  2'b01, 16'd0,     1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'hFFF9, 2'b11, 16'hFFF9, 1'b1};
        vecs[6]  = '{1'b1, 16'd255,  2'b01, 1'b0, 16'h0000, 2'b00, 16'd0,     1'b0};
        vecs[7]  = '{1'b1, 16'd256,  2'b10, 1'b0, 16'h0000, 2'b00, 16'd256,   1'b0};
        vecs[8]  = '{1'b1, 16'h8000, 2'b01, 1'b0, 16'h0000, 2'b00, 16'd127,   1'b0};
        vecs[9]  = '{1'b1, 16'h8000, 2'b10, 1'b0, 16'h0000, 2'b00, 16'd128,   1'b0};
        vecs[10] = '{1'b1, 16'h7FFF, 2'b01, 1'b0, 16'h0000, 2'b00, 16'd127,   1'b0};
        vecs[11] = '{1'b1, 16'h7FFF, 2'b10, 1'b0, 16'h0000, 2'b00, 16'd128,   1'b0};

        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        rst = 1'b1;
        drive(1'b1, 16'd1, 2'b00, 1'b1, 16'd2, 2'b00, 1'b1);
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b0, 16'd0, 2'b00, 1'b0, 16'd0, 2'b00, 1'b1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", {16'd0, out_result}, 32'd0);
        chk("reset_out_src", {31'd0, out_src}, 32'd0);

        // Continuous contention: strict alternation starting with requester 0.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'd100, 2'b00, 1'b1, 16'd200, 2'b00, 1'b1);
            cycle();
            chk("contend_src", {31'd0, out_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
`ifdef MOD_REDUCE_ARB_STATS_EN
        chk("contend_cnt0", {16'd0, grant_cnt0}, 32'd3);
        chk("contend_cnt1", {16'd0, grant_cnt1}, 32'd3);
`endif
        drive(1'b0, 16'd0, 2'b00, 1'b0, 16'd0, 2'b00, 1'b1);
        cycle();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v0, vecs[i].val0, vecs[i].sel0, vecs[i].v1, vecs[i].val1, vecs[i].sel1, 1'b1);
            cycle();
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), {16'd0, out_result}, {16'd0, vecs[i].exp_res});
            chk($sformatf("vec%0d_src", i), {31'd0, out_src}, {31'd0, vecs[i].exp_src});
            drive(1'b0, 16'd0, 2'b00, 1'b0, 16'd0, 2'b00, 1'b1);
            cycle();
        end

        // Backpressure: fill from req0, stall 4 cycles with both valid, release.
        drive(1'b1, 16'hFFFB, 2'b01, 1'b0, 16'd0, 2'b00, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'd7, 2'b00, 1'b1, 16'd9, 2'b10, 1'b0);
            #1;
            chk("stall_ready0", {31'd0, req0_ready}, 32'd0);
            chk("stall_ready1", {31'd0, req1_ready}, 32'd0);
            chk("stall_result", {16'd0, out_result}, 32'd250);
            cycle();
        end
        drive(1'b1, 16'd7, 2'b00, 1'b1, 16'd9, 2'b10, 1'b1);
        #1;
        chk("release_ready1", {31'd0, req1_ready}, 32'd1);
        chk("release_ready0", {31'd0, req0_ready}, 32'd0);
        cycle();
        chk("release_valid", {31'd0, out_valid}, 32'd1);
        chk("release_src", {31'd0, out_src}, 32'd1);
        chk("release_result", {16'd0, out_result}, 32'd9);

        // Reset while full with a pending request.
        drive(1'b0, 16'd0, 2'b00, 1'b1, 16'd33, 2'b00, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_full_result", {16'd0, out_result}, 32'd0);
        drive(1'b1, 16'd11, 2'b00, 1'b1, 16'd22, 2'b00, 1'b1);
        #1;
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        cycle();

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0));
            cycle();
        end
        drive(1'b0, 16'd0, 2'b00, 1'b0, 16'd0, 2'b00, 1'b1);
        cycle();
        cycle();

`ifdef MOD_REDUCE_ARB_STATS_EN
        drive(1'b1, 16'd1, 2'b00, 1'b0, 16'd0, 2'b00, 1'b1);
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt0", {16'd0, grant_cnt0}, 32'd65535);
        chk("sat_cnt1", {16'd0, grant_cnt1}, m_cnt1);
        drive(1'b0, 16'd0, 2'b00, 1'b0, 16'd0, 2'b00, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
